// File: rtl/conv3x3_mac_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution MAC block.
//   - conv_state_e : window FSM states (IDLE, MAC, BIAS, DONE)
//   - DATA_W       : weight / pixel width
//   - ADDR_W       : row / column address width
//   - IMG_DIM      : image side length
//   - K_DIM        : kernel side length
//   - ACC_W        : accumulator / bias / result width
//   - PROD_W       : signed x unsigned product width (2*DATA_W+1)
package conv_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int IMG_DIM = 28;
  localparam int K_DIM   = 3;
  localparam int ACC_W   = 33;
  localparam int PROD_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } conv_state_e;

endpackage

// File: rtl/conv3x3_mac_mac_unit.sv
// mac_unit: signed-weight x unsigned-pixel multiply-accumulate.
// The pixel is zero-extended by one bit so the product can be formed as a
// plain signed multiply; the product is sign-extended into the accumulator.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear of the accumulator (wins over en)
//   en        : add the current product this cycle
//   w         : signed weight
//   p         : unsigned pixel
//   acc       : signed running sum
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 33
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] w,
  input  logic        [DATA_W-1:0] p,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W + 1;

  logic signed [PROD_W-1:0] prod;

  assign prod = w * $signed({1'b0, p});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: computes one 3x3 convolution window over a 28x28 image.
// A start in IDLE (with the filter memory loaded and the window in range)
// walks the 9 kernel taps in row-major order, one tap per cycle, then adds
// the filter bias and presents a registered result with a one-cycle done.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
//
// Handshake: start is a level sampled only in IDLE; busy covers MAC and
// BIAS; done is a one-cycle pulse with result held until the next window
// completes; err pulses one cycle after a rejected (out-of-range) start.
//
// Ports:
//   clk, rstn                : clock, asynchronous active-low reset
//   start, base_row/base_col : window request and top-left corner
//   busy, done, err, result  : status and signed result
//   f_sel/f_wr/f_get_b/f_addr1/f_addr2, f_rdata/f_rbias/f_full : filter memory
//   img_sel/img_row/img_col, img_rdata                         : image memory
//   dbg_state                : current FSM state
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int DATA_W  = conv_pkg::DATA_W,
  parameter int ADDR_W  = conv_pkg::ADDR_W,
  parameter int IMG_DIM = conv_pkg::IMG_DIM,
  parameter int K_DIM   = conv_pkg::K_DIM,
  parameter int ACC_W   = conv_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic        [ADDR_W-1:0] base_row,
  input  logic        [ADDR_W-1:0] base_col,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic signed [ACC_W-1:0]  result,
  output logic                     f_sel,
  output logic                     f_wr,
  output logic                     f_get_b,
  output logic        [ADDR_W-1:0] f_addr1,
  output logic        [ADDR_W-1:0] f_addr2,
  input  logic signed [DATA_W-1:0] f_rdata,
  input  logic signed [ACC_W-1:0]  f_rbias,
  input  logic                     f_full,
  output logic                     img_sel,
  output logic        [ADDR_W-1:0] img_row,
  output logic        [ADDR_W-1:0] img_col,
  input  logic        [DATA_W-1:0] img_rdata,
  output conv_state_e              dbg_state
);

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K_DIM - 1);
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(IMG_DIM - K_DIM);

  conv_state_e state, state_d;

  logic [ADDR_W-1:0] cnt_i, cnt_j;
  logic [ADDR_W-1:0] row_q, col_q;
  logic              in_range;
  logic              req;
  logic              accept;
  logic              last_tap;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] biased;

  assign in_range = (base_row <= MAX_BASE) && (base_col <= MAX_BASE);
  assign req      = (state == IDLE) && start && f_full;
  assign accept   = req && in_range;
  assign last_tap = (cnt_i == K_LAST) && (cnt_j == K_LAST);
  assign biased   = acc + f_rbias;

  assign f_wr      = 1'b0;
  assign dbg_state = state;

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rstn (rstn),
    .clr  (accept),
    .en   (state == MAC),
    .w    (f_rdata),
    .p    (img_rdata),
    .acc  (acc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    f_sel   = 1'b0;
    f_get_b = 1'b0;
    f_addr1 = '0;
    f_addr2 = '0;
    img_sel = 1'b0;
    img_row = '0;
    img_col = '0;
    case (state)
      IDLE: begin
        if (accept) state_d = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        f_sel   = 1'b1;
        f_addr1 = cnt_i;
        f_addr2 = cnt_j;
        img_sel = 1'b1;
        img_row = row_q + cnt_i;
        img_col = col_q + cnt_j;
        if (last_tap) state_d = BIAS;
      end
      BIAS: begin
        busy    = 1'b1;
        f_sel   = 1'b1;
        f_get_b = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tap counters walk the kernel row-major: j is the fast index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_i <= '0;
      cnt_j <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      cnt_i <= '0;
      cnt_j <= '0;
      row_q <= base_row;
      col_q <= base_col;
    end else if (state == MAC) begin
      if (cnt_j == K_LAST) begin
        cnt_j <= '0;
        cnt_i <= cnt_i + 1'b1;
      end else begin
        cnt_j <= cnt_j + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else begin
      err <= req && !in_range;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result <= '0;
    end else if (state == BIAS) begin
`ifdef CONV_RELU_EN
      result <= biased[ACC_W-1] ? '0 : biased;
`else
      result <= biased;
`endif
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
module tb_conv3x3_mac;
  import conv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                     start;
  logic        [ADDR_W-1:0] base_row, base_col;
  logic                     busy, done, err;
  logic signed [ACC_W-1:0]  result;
  logic                     f_sel, f_wr, f_get_b;
  logic        [ADDR_W-1:0] f_addr1, f_addr2;
  logic signed [DATA_W-1:0] f_rdata;
  logic signed [ACC_W-1:0]  f_rbias;
  logic                     f_full;
  logic                     img_sel;
  logic        [ADDR_W-1:0] img_row, img_col;
  logic        [DATA_W-1:0] img_rdata;
  conv_state_e              dbg_state;

  // ---------------- memory models ----------------
  int          wt [0:2][0:2];
  int          bias_v;
  logic [7:0]  img [0:IMG_DIM-1][0:IMG_DIM-1];

  always_comb begin
    int wv;
    wv      = 0;
    if (f_addr1 < 3 && f_addr2 < 3) wv = wt[f_addr1][f_addr2];
    f_rdata = wv[DATA_W-1:0];
    f_rbias = ACC_W'(bias_v);
    img_rdata = 8'd0;
    if (img_row < IMG_DIM && img_col < IMG_DIM) img_rdata = img[img_row][img_col];
  end

  conv3x3_mac dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_row  (base_row),
    .base_col  (base_col),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .f_sel     (f_sel),
    .f_wr      (f_wr),
    .f_get_b   (f_get_b),
    .f_addr1   (f_addr1),
    .f_addr2   (f_addr2),
    .f_rdata   (f_rdata),
    .f_rbias   (f_rbias),
    .f_full    (f_full),
    .img_sel   (img_sel),
    .img_row   (img_row),
    .img_col   (img_col),
    .img_rdata (img_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [ACC_W-1:0] exp_q[$];

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint relu(input longint v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint ref_conv(input int r, input int c);
    longint s;
    s = longint'(bias_v);
    for (int ki = 0; ki < 3; ki++)
      for (int kj = 0; kj < 3; kj++)
        s += longint'(wt[ki][kj]) * longint'({56'd0, img[r+ki][c+kj]});
    return relu(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_filter_default();
    int w0 [0:8];
    w0 = '{-127, -7, -64, -82, 34, -60, -43, 64, 48};
    for (int k = 0; k < 9; k++) wt[k/3][k%3] = w0[k];
    bias_v = -998;
  endtask

  task automatic fill_image(input int v);
    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++) img[r][c] = 8'(v);
  endtask

  // Issues one window, checks tap addressing, latency, result and hold.
  task automatic run_window(input string tag, input int r, input int c,
                            input bit poke_start, input bit drop_full);
    int  lat;
    int  sweep_err;
    bit  got;
    logic [ACC_W-1:0] expv;
    exp_q.push_back(ACC_W'(ref_conv(r, c)));
    base_row = ADDR_W'(r);
    base_col = ADDR_W'(c);
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, longint'(busy), 1);
    lat = 0; sweep_err = 0; got = 1'b0;
    while (lat < 20 && !got) begin
      if (lat < 9) begin
        if (!(img_sel && f_sel && !f_get_b &&
              int'(img_row) == r + lat/3 && int'(img_col) == c + lat%3 &&
              int'(f_addr1) == lat/3 && int'(f_addr2) == lat%3))
          sweep_err++;
      end else if (lat == 9) begin
        if (!(f_sel && f_get_b && !img_sel)) sweep_err++;
      end
      start = (poke_start && lat == 3);
      if (poke_start && lat == 3) begin
        base_row = 5'd1;
        base_col = 5'd1;
      end
      if (drop_full && lat == 4) f_full = 1'b0;
      if (done) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    start  = 1'b0;
    f_full = 1'b1;
    expv = exp_q.pop_front();
    // Start cycle plus ten further cycles before done.
    check({tag, "_latency"}, lat, 10);
    check({tag, "_sweep"}, sweep_err, 0);
    check({tag, "_result"}, longint'($signed(result)), longint'($signed(expv)));
    check({tag, "_busy_in_done"}, longint'(busy), 0);
    tick();
    check({tag, "_done_pulse"}, longint'(done), 0);
    check({tag, "_result_hold"}, longint'($signed(result)), longint'($signed(expv)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rstn = 1'b0; start = 1'b0; base_row = '0; base_col = '0; f_full = 1'b1;
    load_filter_default();
    fill_image(1);
    repeat (2) tick();
    check("rst_state", longint'(dbg_state), longint'(IDLE));
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check("rst_result", longint'(result), 0);
    check("rst_sel", longint'({f_sel, f_get_b, img_sel, f_wr}), 0);
    check("rst_addr", longint'({f_addr1, f_addr2, img_row, img_col}), 0);
    rstn = 1'b1;
    tick();

    // 1: all ones at (0,0)
    fill_image(1);
    run_window("t1", 0, 0, 0, 0);
    check("t1_const", longint'($signed(result)), relu(-1235));

    // 2: zeros at the far corner, sweeps rows/cols 25..27
    fill_image(0);
    run_window("t2", 25, 25, 0, 0);
    check("t2_const", longint'($signed(result)), relu(-998));

    // 3: single centre pixel
    fill_image(0);
    img[11][11] = 8'd255;
    run_window("t3", 10, 10, 0, 0);
    check("t3_const", longint'($signed(result)), 7672);

    // 4: saturated image
    fill_image(255);
    run_window("t4", 5, 7, 0, 0);
    check("t4_const", longint'($signed(result)), relu(-61433));

    // 5: out-of-range window, then start without a loaded filter
    base_row = 5'd26; base_col = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_err_row", longint'(err), 1);
    check("t5_busy_row", longint'(busy), 0);
    tick();
    check("t5_err_clear", longint'(err), 0);
    check("t5_state_row", longint'(dbg_state), longint'(IDLE));
    base_row = 5'd0; base_col = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_err_col", longint'(err), 1);
    tick();
    f_full = 1'b0; base_row = 5'd0; base_col = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_nofull_busy", longint'(busy), 0);
    check("t5_nofull_err", longint'(err), 0);
    tick();
    check("t5_nofull_state", longint'(dbg_state), longint'(IDLE));
    f_full = 1'b1;

    // 6: reset during MAC, then recovery with busy starts and f_full drop
    fill_image(1);
    base_row = 5'd0; base_col = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    check("t6_rst_busy", longint'(busy), 0);
    check("t6_rst_done", longint'(done), 0);
    check("t6_rst_state", longint'(dbg_state), longint'(IDLE));
    tick();
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) seen++;
    end
    check("t6_no_done", seen, 0);
    run_window("t6", 0, 0, 1, 1);
    check("t6_const", longint'($signed(result)), relu(-1235));

    // Randomized windows against the reference model
    for (int t = 0; t < 8; t++) begin
      for (int ki = 0; ki < 3; ki++)
        for (int kj = 0; kj < 3; kj++)
          wt[ki][kj] = int'($urandom_range(255)) - 128;
      bias_v = int'($urandom);
      for (int r = 0; r < IMG_DIM; r++)
        for (int c = 0; c < IMG_DIM; c++) img[r][c] = 8'($urandom_range(255));
      run_window($sformatf("rnd%0d", t), int'($urandom_range(25)),
                 int'($urandom_range(25)), t[0], t[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
